// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits; one bit = CLK_FREQ/BAUD clocks).
// Build option UART_TX_FIFO_EN: define it to buffer writes in a FIFO_DEPTH-word
// FIFO; leave it undefined for a single holding register that is only writable
// while the line is idle.
module uart_tx_cfg #(
  parameter int BAUD       = 115200,
  parameter int CLK_FREQ   = 27_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [DATA_BITS-1:0] pi_data,
  input  logic                 pi_flag,
  output logic                 pi_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int            P         = CLK_FREQ / BAUD;
  localparam int            CW        = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] P_LAST    = CW'(P - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  // Parameter legality, caught at elaboration rather than as a broken netlist.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (P < 2) begin : g_bad_period
    $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_q, tx_d;
  logic                 rdy_q;

  logic                 bit_end;
  logic                 push;
  logic                 start_ok;      // a word may start a frame from IDLE
  logic                 next_pending;  // another word is ready at the end of STOP
  logic                 start_frame;
  logic [DATA_BITS-1:0] frame_word;
  logic [DATA_BITS-1:0] shifted;

  assign bit_end = (baud_q == P_LAST);
  assign push    = pi_flag && pi_ready;
  assign tx      = tx_q;
  assign busy    = (state_q != ST_IDLE);
  assign tx_done = (state_q == ST_STOP) && bit_end && (bit_q == LAST_STOP);

`ifdef UART_TX_FIFO_EN
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  // The word on the line stays at the head until its tx_done, so a full FIFO
  // holds FIFO_DEPTH words including the one being sent.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]          count_q, queued;
  logic                 queued_q;

  assign rd_next      = rd_ptr_q + AW'(1);
  assign queued       = count_q - {{AW{1'b0}}, busy};
  assign pi_ready     = rdy_q && (count_q != DEPTH_C);
  // Waiting words are seen one cycle late from IDLE, giving the k+2 start.
  assign start_ok     = queued_q;
  assign next_pending = (count_q > (AW + 1)'(1));
  assign frame_word   = busy ? mem_q[rd_next] : mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; count_q guards every read, so stale
  // entries are never used and the array can map onto plain RAM.
  // FIFO storage write port.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= pi_data;
  end

  // FIFO pointers, occupancy and the registered "word waiting" flag.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      queued_q <= 1'b0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (tx_done) rd_ptr_q <= rd_next;
      case ({push, tx_done})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      queued_q <= (queued != '0);
    end
  end
`else
  logic [DATA_BITS-1:0] hold_q;
  logic                 pending_q;

  assign pi_ready     = rdy_q && (state_q == ST_IDLE) && !pending_q;
  assign start_ok     = pending_q;
  assign next_pending = pending_q;
  assign frame_word   = hold_q;

  // Holding register: keeps one accepted word until its frame starts.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_q    <= '0;
      pending_q <= 1'b0;
    end else if (push) begin
      hold_q    <= pi_data;
      pending_q <= 1'b1;
    end else if (start_frame) begin
      pending_q <= 1'b0;
    end
  end
`endif

  // Next-state, bit timing and registered line value for the frame FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d     = state_q;
    baud_d      = bit_end ? '0 : baud_q + CW'(1);
    bit_d       = bit_q;
    start_frame = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (start_ok) begin
          state_d     = ST_START;
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_DATA) begin
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            bit_d = '0;
            if (next_pending) begin
              state_d     = ST_START;
              start_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    data_d  = start_frame ? frame_word : data_q;
    shifted = data_d >> bit_d;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shifted[0];
      ST_PARITY: tx_d = (PARITY == 1) ? ~^data_d : ^data_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so each one samples the
  // pre-edge values of the others regardless of evaluation order.
  // State register, counters, frame data, line driver and ready release.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule
